// File: rtl/vote_pkg.sv
// Shared constants, FSM state type and BCD helper for the vote tally display.
package vote_pkg;

    // Active-high segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Split a tally of at most 99 into {tens, ones} BCD digits.
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] tally);
        logic [6:0] tens_w;
        logic [6:0] ones_w;
        tens_w = tally / 7'd10;
        ones_w = tally % 7'd10;
        return {tens_w[3:0], ones_w[3:0]};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Digit to active-high 7-segment decoder with dash and blank overrides.
module seg7_decoder
    import vote_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] segs_o
);

    // Dash overrides blank, blank overrides the digit pattern.
    always_comb begin
        segs_o = SEG_BLANK;
        if (dash_i) begin
            segs_o = SEG_DASH;
        end else if (blank_i) begin
            segs_o = SEG_BLANK;
        end else begin
            case (digit_i)
                4'd0:    segs_o = SEG_0;
                4'd1:    segs_o = SEG_1;
                4'd2:    segs_o = SEG_2;
                4'd3:    segs_o = SEG_3;
                4'd4:    segs_o = SEG_4;
                4'd5:    segs_o = SEG_5;
                4'd6:    segs_o = SEG_6;
                4'd7:    segs_o = SEG_7;
                4'd8:    segs_o = SEG_8;
                4'd9:    segs_o = SEG_9;
                default: segs_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/vote_tally_display.sv
// Latches a ballot, tallies it one vote per cycle and drives a two-digit
// multiplexed 7-segment display with the decimal result.
module vote_tally_display
    import vote_pkg::*;
#(
    parameter  int N_VOTERS       = 5,
    parameter  int REFRESH_DIV    = 50000,
    parameter  int SEG_ACTIVE_LOW = 0,
    localparam int CNT_W          = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_VOTERS-1:0] votes,
    input  logic                sample,
    input  logic                clear,
    output logic                busy,
    output logic                valid,
    output logic [CNT_W-1:0]    count,
    output logic                majority,
    output logic                tie,
    output logic [6:0]          segs,
    output logic [1:0]          digit_en
);

    localparam int         IDX_W    = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1;
    localparam int         REF_W    = $clog2(REFRESH_DIV);
    localparam logic [6:0] POL_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       N_EVEN   = ((N_VOTERS % 2) == 0);

    state_t              state_q,  state_d;
    logic [N_VOTERS-1:0] ballot_q, ballot_d;
    logic [CNT_W-1:0]    acc_q,    acc_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic                valid_q,  valid_d;

    logic [REF_W-1:0]    refresh_q, refresh_d;
    logic [1:0]          digit_en_q, digit_en_d;
    logic [6:0]          segs_q, segs_d;

    logic                ref_wrap_s;
    logic [7:0]          bcd_s;
    logic [3:0]          mux_digit_s;
    logic                mux_blank_s;
    logic [6:0]          dec_segs_s;

    // Tally FSM: clear beats sample; sample only accepted outside COUNT.
    always_comb begin
        state_d  = state_q;
        ballot_d = ballot_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (clear) begin
            state_d  = ST_IDLE;
            ballot_d = '0;
            acc_d    = '0;
            idx_d    = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (sample) begin
                        state_d  = ST_COUNT;
                        ballot_d = votes;
                        acc_d    = '0;
                        idx_d    = '0;
                        valid_d  = 1'b0;
                    end else begin
                        state_d  = state_q;
                    end
                end
                ST_COUNT: begin
                    acc_d = acc_q + CNT_W'(ballot_q[idx_q]);
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N_VOTERS - 1)) begin
                        count_d = acc_d;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Tally state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ballot_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ballot_q <= ballot_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign busy     = (state_q == ST_COUNT);
    assign valid    = valid_q;
    assign count    = count_q;
    assign majority = valid_q && (count_q > CNT_W'(N_VOTERS / 2));
    assign tie      = valid_q && N_EVEN && (count_q == CNT_W'(N_VOTERS / 2));

    assign bcd_s = bin_to_bcd2(7'(count_q));

    // Refresh counter and digit slot selection; segs follow the next slot
    // so both change on the same edge.
    always_comb begin
        ref_wrap_s = (refresh_q == REF_W'(REFRESH_DIV - 1));
        if (ref_wrap_s) begin
            refresh_d  = '0;
            digit_en_d = {digit_en_q[0], digit_en_q[1]};
        end else begin
            refresh_d  = refresh_q + REF_W'(1);
            digit_en_d = digit_en_q;
        end
        if (digit_en_d[0]) begin
            mux_digit_s = bcd_s[3:0];
            mux_blank_s = 1'b0;
        end else begin
            mux_digit_s = bcd_s[7:4];
            mux_blank_s = (bcd_s[7:4] == 4'd0);
        end
        segs_d = dec_segs_s ^ POL_MASK;
    end

    seg7_decoder u_dec (
        .digit_i (mux_digit_s),
        .blank_i (mux_blank_s),
        .dash_i  (!valid_q),
        .segs_o  (dec_segs_s)
    );

    // Display registers: refresh count, digit enable and segment drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q  <= '0;
            digit_en_q <= 2'b01;
            segs_q     <= SEG_DASH ^ POL_MASK;
        end else begin
            refresh_q  <= refresh_d;
            digit_en_q <= digit_en_d;
            segs_q     <= segs_d;
        end
    end

    assign segs     = segs_q;
    assign digit_en = digit_en_q;

endmodule

// File: tb/tb_vote_tally_display.sv
// Directed bench for vote_tally_display with a scoreboard of expected tallies.
module tb_vote_tally_display;

    typedef struct {
        logic [6:0] cnt;
        logic       maj;
        logic       tie;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [4:0]  votes5  = 5'd0;
    logic        sample5 = 1'b0;
    logic        clear5  = 1'b0;
    logic        busy5, valid5, maj5, tie5;
    logic [2:0]  count5;
    logic [6:0]  segs5;
    logic [1:0]  de5;

    logic        busy5n, valid5n, maj5n, tie5n;
    logic [2:0]  count5n;
    logic [6:0]  segs5n;
    logic [1:0]  de5n;

    logic [11:0] votes12  = 12'd0;
    logic        sample12 = 1'b0;
    logic        clear12  = 1'b0;
    logic        busy12, valid12, maj12, tie12;
    logic [3:0]  count12;
    logic [6:0]  segs12;
    logic [1:0]  de12;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    vote_tally_display #(.N_VOTERS(5), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0)) u5 (
        .clk(clk), .rst(rst), .votes(votes5), .sample(sample5), .clear(clear5),
        .busy(busy5), .valid(valid5), .count(count5), .majority(maj5), .tie(tie5),
        .segs(segs5), .digit_en(de5));

    vote_tally_display #(.N_VOTERS(5), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1)) u5n (
        .clk(clk), .rst(rst), .votes(votes5), .sample(sample5), .clear(clear5),
        .busy(busy5n), .valid(valid5n), .count(count5n), .majority(maj5n), .tie(tie5n),
        .segs(segs5n), .digit_en(de5n));

    vote_tally_display #(.N_VOTERS(12), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0)) u12 (
        .clk(clk), .rst(rst), .votes(votes12), .sample(sample12), .clear(clear12),
        .busy(busy12), .valid(valid12), .count(count12), .majority(maj12), .tie(tie12),
        .segs(segs12), .digit_en(de12));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_valid(input int inst);
        if (inst == 2) return valid12;
        else if (inst == 1) return valid5n;
        else return valid5;
    endfunction

    function automatic logic get_busy(input int inst);
        if (inst == 2) return busy12;
        else return busy5;
    endfunction

    function automatic logic [6:0] get_count(input int inst);
        if (inst == 2) return 7'(count12);
        else return 7'(count5);
    endfunction

    function automatic logic get_maj(input int inst);
        if (inst == 2) return maj12;
        else return maj5;
    endfunction

    function automatic logic get_tie(input int inst);
        if (inst == 2) return tie12;
        else return tie5;
    endfunction

    function automatic logic [6:0] get_segs(input int inst);
        if (inst == 2) return segs12;
        else if (inst == 1) return segs5n;
        else return segs5;
    endfunction

    function automatic logic [1:0] get_de(input int inst);
        if (inst == 2) return de12;
        else if (inst == 1) return de5n;
        else return de5;
    endfunction

    // Drive the sample pulse, push the expected result, and step over E0.
    task automatic tally_start(input int inst, input logic [11:0] v);
        int          n;
        logic [11:0] m;
        exp_t        e;
        n = (inst == 2) ? 12 : 5;
        m = v & ((12'd1 << n) - 12'd1);
        e.cnt = 7'($countones(m));
        e.maj = (e.cnt > 7'(n / 2));
        e.tie = ((n % 2) == 0) && (e.cnt == 7'(n / 2));
        sb.push_back(e);
        if (inst == 2) begin
            votes12  = v;
            sample12 = 1'b1;
        end else begin
            votes5  = v[4:0];
            sample5 = 1'b1;
        end
        tick();
        sample5  = 1'b0;
        sample12 = 1'b0;
        chk("busy_after_sample", get_busy(inst), 16'd1);
        chk("valid_low_in_count", get_valid(inst), 16'd0);
    endtask

    // Wait (bounded) for valid, check latency, pop the scoreboard and compare.
    task automatic tally_finish(input int inst, input int cyc0);
        int   n;
        int   cyc;
        exp_t e;
        n   = (inst == 2) ? 12 : 5;
        cyc = cyc0;
        while (get_valid(inst) !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("valid_rise", get_valid(inst), 16'd1);
        chk("latency", 16'(cyc), 16'(n));
        chk("sb_nonempty", 16'(sb.size() > 0), 16'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("count", get_count(inst), 16'(e.cnt));
            chk("majority", get_maj(inst), 16'(e.maj));
            chk("tie", get_tie(inst), 16'(e.tie));
        end else begin
            chk("sb_pop", 16'd0, 16'd1);
        end
        chk("busy_done", get_busy(inst), 16'd0);
    endtask

    // Watch 12 cycles of multiplexing: per-slot segs and 4-cycle slot length.
    task automatic disp(input int inst, input logic [6:0] ones, input logic [6:0] tens);
        logic [1:0] de;
        logic [1:0] prev;
        logic [6:0] sg;
        int         run;
        bit         started;
        prev    = get_de(inst);
        run     = 0;
        started = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            de = get_de(inst);
            sg = get_segs(inst);
            chk("digit_onehot", 16'(de == 2'b01 || de == 2'b10), 16'd1);
            if (de == 2'b01) chk("seg_ones", sg, ones);
            else chk("seg_tens", sg, tens);
            if (de != prev) begin
                if (started) chk("slot_len", 16'(run), 16'd4);
                started = 1'b1;
                run     = 1;
            end else begin
                run++;
            end
            prev = de;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_valid", valid5, 16'd0);
        chk("rst_busy", busy5, 16'd0);
        chk("rst_count", count5, 16'd0);
        chk("rst_maj", maj5, 16'd0);
        chk("rst_tie", tie5, 16'd0);
        chk("rst_de", de5, 16'h1);
        chk("rst_segs", segs5, 16'h40);
        chk("rst_de12", de12, 16'h1);

        // Basic tally of 3 out of 5
        tally_start(0, 12'b10110);
        tally_finish(0, 0);
        disp(0, 7'b1001111, 7'b0000000);
        disp(1, 7'b0110000, 7'b1111111);

        // Sample during COUNT is ignored
        tally_start(0, 12'b10110);
        tick();
        tick();
        votes5  = 5'b11111;
        sample5 = 1'b1;
        tick();
        sample5 = 1'b0;
        chk("busy_ignored_sample", busy5, 16'd1);
        tally_finish(0, 3);

        // Further 5-voter ballots, including all-yes and all-no
        tally_start(0, 12'b11111);
        tally_finish(0, 0);
        disp(0, 7'b1101101, 7'b0000000);
        tally_start(0, 12'b00011);
        tally_finish(0, 0);
        tally_start(0, 12'b00000);
        tally_finish(0, 0);
        disp(0, 7'b0111111, 7'b0000000);

        // 12-voter: two-digit result and exact tie
        tally_start(2, 12'hFFF);
        tally_finish(2, 0);
        disp(2, 7'b1011011, 7'b0000110);
        tally_start(2, 12'h03F);
        tally_finish(2, 0);

        // Clear together with sample while in HOLD
        tally_start(0, 12'b01110);
        tally_finish(0, 0);
        votes5  = 5'b11111;
        clear5  = 1'b1;
        sample5 = 1'b1;
        tick();
        clear5  = 1'b0;
        sample5 = 1'b0;
        chk("clr_valid", valid5, 16'd0);
        chk("clr_busy", busy5, 16'd0);
        chk("clr_count", count5, 16'd0);
        chk("clr_maj", maj5, 16'd0);
        tick();
        chk("clr_stay_idle", busy5, 16'd0);
        disp(0, 7'b1000000, 7'b1000000);

        // Clear at idx=2 of COUNT
        tally_start(0, 12'b11011);
        tally_finish(0, 0);
        tally_start(0, 12'b11111);
        tick();
        tick();
        clear5 = 1'b1;
        tick();
        clear5 = 1'b0;
        sb.delete();
        chk("clr2_busy", busy5, 16'd0);
        chk("clr2_valid", valid5, 16'd0);
        chk("clr2_count", count5, 16'd0);
        repeat (8) tick();
        chk("clr2_no_result", valid5, 16'd0);
        chk("clr2_idle", busy5, 16'd0);

        // Asynchronous reset in the middle of a tally
        tally_start(0, 12'b10101);
        tally_finish(0, 0);
        tally_start(0, 12'b11111);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", valid5, 16'd0);
        chk("arst_busy", busy5, 16'd0);
        chk("arst_count", count5, 16'd0);
        chk("arst_maj", maj5, 16'd0);
        chk("arst_de", de5, 16'h1);
        chk("arst_segs", segs5, 16'h40);
        #3 rst = 1'b0;
        sb.delete();
        repeat (6) tick();
        chk("arst_idle_busy", busy5, 16'd0);
        chk("arst_idle_valid", valid5, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vote_tally_display.md
# vote_tally_display

Parametrised, clocked successor to the combinational five-input vote display. It latches a ballot of N_VOTERS vote lines on a sample strobe and tallies it serially with a small FSM. It reports count, majority and tie flags, and drives a two-digit multiplexed 7-segment display showing the tally in decimal. It sits between the voter input lines and the board's display pins.

## Interface
- N_VOTERS, 5, number of vote lines; legal range 1..99
- REFRESH_DIV, 50000, clk cycles per display digit slot; minimum 2
- SEG_ACTIVE_LOW, 0, 1 inverts `segs` for common-anode displays
- CNT_W, $clog2(N_VOTERS+1), derived localparam, tally width
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- votes  in  N_VOTERS  vote lines, 1 = yes; sampled only on `sample`
- sample  in  1  one-cycle strobe: latch `votes` and start tally
- clear  in  1  synchronous clear of result and FSM
- busy  out  1  tally in progress
- valid  out  1  `count`, `majority` and `tie` hold a completed tally
- count  out  CNT_W  number of yes votes in last ballot
- majority  out  1  count > N_VOTERS/2, strictly more than half
- tie  out  1  N_VOTERS even and count == N_VOTERS/2
- segs  out  7  segment drive; segs[0]=a … segs[6]=g
- digit_en  out  2  one-hot digit enable; bit0 = ones, bit1 = tens

## Operation
- FSM states: IDLE, COUNT, HOLD.
- IDLE→COUNT and HOLD→COUNT on `sample`=1 with `clear`=0. Actions: ballot ← votes, acc ← 0, idx ← 0, valid ← 0.
- COUNT, each cycle: acc ← acc + ballot[idx], idx ← idx+1.
  - When idx == N_VOTERS−1: count ← acc + ballot[idx], valid ← 1, state ← HOLD.
- `sample` while in COUNT is ignored; it is not queued.
- `clear` has priority over `sample` in any state. Actions: state ← IDLE, count ← 0, valid ← 0, ballot/acc/idx ← 0.
- `busy` = (state == COUNT).
- `majority` and `tie` are combinational from `count`. Both are gated by `valid`, so they are 0 whenever valid=0.
- `count` keeps its previous value while a new tally runs.
- Display content:
  - valid=1: ones digit = count mod 10; tens digit = count/10; tens digit blank (all segments off) when count < 10.
  - valid=0: both digits show dash (segment g only).
- Segment codes follow standard a–g patterns, e.g. 3 = 7'b1001111, 1 = 7'b0000110, dash = 7'b1000000.
- SEG_ACTIVE_LOW inverts `segs` only. `digit_en` is always active-high.

## Timing
- Reset values: state IDLE, busy 0, valid 0, count 0, majority 0, tie 0.
- Reset values, display: digit_en 2'b01, refresh counter 0, segs = dash (active-high encoding).
- Tally latency: the `sample` edge is E0; busy is high after edges E0..E(N−1). count and valid update at edge EN. So valid rises N_VOTERS cycles after the sampling edge.
- Refresh counter counts 0..REFRESH_DIV−1. On wrap, `digit_en` toggles between 01 and 10.
- `segs` is registered and updates on the same edge as `digit_en`, so no glitching across digits.
- A count update mid-slot appears on `segs` at the next edge, without waiting for a slot boundary.
- `rst` asserted mid-tally: all outputs take reset values immediately, without waiting for a clock edge. After release the block waits in IDLE.
- `clear` and `sample` in the same cycle: `clear` wins and the FSM stays in IDLE.

## Structure
- Package `vote_pkg` holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - FSM state enum;
  - function `bin_to_bcd2` (tally → tens, ones).
- Sub-module `seg7_decoder`:
  - inputs: 4-bit digit, `blank`, `dash`;
  - output: 7-bit active-high segments;
  - one instance, fed by the digit mux.
- Top level contains the FSM/accumulator, BCD split, refresh counter, digit mux and output register.

## Test plan
- Reset: assert rst asynchronously mid-cycle → valid=0, busy=0, count=0, digit_en=01, segs=7'b1000000 without a clock edge.
- N_VOTERS=5, REFRESH_DIV=4, votes=5'b10110, sample pulse → busy high 5 cycles; at edge E5 count=3, majority=1, tie=0. Ones slot segs=7'b1001111; tens slot segs=7'b0000000; digit_en alternates every 4 cycles.
- Same configuration, second `sample` two cycles into COUNT with votes=5'b11111 → ignored; result still count=3, then a new sample yields count=5.
- N_VOTERS=12, votes=12'hFFF → count=12, tens slot 7'b0000110. Then votes=12'h03F → count=6, tie=1, majority=0.
- `clear` asserted together with `sample` in HOLD, and separately at idx=2 of COUNT → state IDLE, valid=0, count=0, segs show dash in both slots.
- SEG_ACTIVE_LOW=1, count=3 → ones slot segs=7'b0110000; digit_en polarity unchanged.
